// File: rtl/l2_cache_assoc.sv
// -----------------------------------------------------------------------------
// l2_cache_assoc
//   N-way set-associative, write-back, write-allocate L2 cache with tree
//   pseudo-LRU replacement. One outstanding full-line request at a time.
//   Reset clears every valid, dirty and PLRU bit; the data and tag arrays are
//   left untouched.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   mem_read / mem_write        upstream line request, held until mem_resp
//   mem_address, mem_wdata      request address (offset ignored), write line
//   mem_rdata, mem_resp         read line and one-cycle completion pulse
//   pmem_read / pmem_write      memory line request, held until pmem_resp
//   pmem_address, pmem_wdata    line-aligned memory address, write-back line
//   pmem_rdata, pmem_resp       fill line and memory completion pulse
// -----------------------------------------------------------------------------
module l2_cache_assoc #(
   parameter int WAYS      = 4,
   parameter int SET_BITS  = 3,
   parameter int LINE_BITS = 256,
   parameter int ADDR_W    = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mem_read,
   input  logic                 mem_write,
   input  logic [ADDR_W-1:0]    mem_address,
   input  logic [LINE_BITS-1:0] mem_wdata,
   output logic [LINE_BITS-1:0] mem_rdata,
   output logic                 mem_resp,
   output logic                 pmem_read,
   output logic                 pmem_write,
   output logic [ADDR_W-1:0]    pmem_address,
   output logic [LINE_BITS-1:0] pmem_wdata,
   input  logic [LINE_BITS-1:0] pmem_rdata,
   input  logic                 pmem_resp
);

   localparam int OFS   = $clog2(LINE_BITS / 8);
   localparam int SETS  = 1 << SET_BITS;
   localparam int LA_W  = ADDR_W - OFS;          // line address width
   localparam int TAG_W = LA_W - SET_BITS;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int NODES = WAYS - 1;              // PLRU tree bits per set

   typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WB, S_FILL} state_t;

   state_t              state_q, state_d;
   logic [LA_W-1:0]     line_q, line_d;          // latched line address
   logic                wr_q, wr_d;
   logic [WAY_W-1:0]    victim_q, victim_d;

   logic [WAYS-1:0]     valid_q [SETS];
   logic [WAYS-1:0]     valid_d [SETS];
   logic [WAYS-1:0]     dirty_q [SETS];
   logic [WAYS-1:0]     dirty_d [SETS];
   logic [NODES-1:0]    plru_q  [SETS];
   logic [NODES-1:0]    plru_d  [SETS];

   logic [TAG_W-1:0]     tag_mem  [SETS][WAYS];
   logic [LINE_BITS-1:0] data_mem [SETS][WAYS];

   logic [SET_BITS-1:0]  idx;
   logic [TAG_W-1:0]     req_tag;
   logic [WAYS-1:0]      hit_vec;
   logic                 hit;
   logic [WAY_W-1:0]     hit_way, inv_way, plru_way, victim;
   logic                 inv_found;

   logic                 line_we, tag_we;
   logic [WAY_W-1:0]     line_way;
   logic [LINE_BITS-1:0] line_data;

   // Offset bits of the request address are don't-care.
   logic unused_ofs;
   assign unused_ofs = ^mem_address[OFS-1:0];

   assign idx     = line_q[SET_BITS-1:0];
   assign req_tag = line_q[LA_W-1:SET_BITS];

   for (genvar gi = 0; gi < WAYS; gi++) begin : g_hit
      assign hit_vec[gi] = valid_q[idx][gi] && (tag_mem[idx][gi] == req_tag);
   end
   assign hit = |hit_vec;

   // Tree layout: node n has children 2n+1 (bit=0) and 2n+2 (bit=1);
   // leaves NODES..2*NODES map to ways 0..WAYS-1. Bits point at the victim.
   function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] bits,
                                                   input logic [WAY_W-1:0] way);
      logic [NODES-1:0] r;
      int               n;
      logic             dir;
      r = bits;
      n = 0;
      for (int l = 0; l < WAY_W; l++) begin
         dir  = way[WAY_W-1-l];
         r[n] = ~dir;                 // point away from the accessed way
         n    = 2 * n + 1 + int'(dir);
      end
      return r;
   endfunction

   always_comb begin
      int n;
      hit_way   = '0;
      inv_way   = '0;
      inv_found = 1'b0;
      // Downward scans so the lowest matching index wins.
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (hit_vec[w]) hit_way = WAY_W'(w);
         if (!valid_q[idx][w]) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
      end
      n = 0;
      for (int l = 0; l < WAY_W; l++) n = 2 * n + 1 + int'(plru_q[idx][n]);
      plru_way = WAY_W'(n - NODES);
      victim   = inv_found ? inv_way : plru_way;
   end

   always_comb begin
      state_d      = state_q;
      line_d       = line_q;
      wr_d         = wr_q;
      victim_d     = victim_q;
      valid_d      = valid_q;
      dirty_d      = dirty_q;
      plru_d       = plru_q;
      line_we      = 1'b0;
      tag_we       = 1'b0;
      line_way     = '0;
      line_data    = '0;
      mem_resp     = 1'b0;
      mem_rdata    = '0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      case (state_q)
         S_IDLE: begin
            if (mem_read || mem_write) begin
               line_d  = mem_address[ADDR_W-1:OFS];
               wr_d    = mem_write;           // write wins if both are raised
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (hit) begin
               mem_resp = 1'b1;
               if (wr_q) begin
                  line_we               = 1'b1;
                  line_way              = hit_way;
                  line_data             = mem_wdata;
                  dirty_d[idx][hit_way] = 1'b1;
               end else begin
                  mem_rdata = data_mem[idx][hit_way];
               end
               plru_d[idx] = plru_touch(plru_q[idx], hit_way);
               state_d     = S_IDLE;
            end else begin
               victim_d = victim;
               state_d  = (valid_q[idx][victim] && dirty_q[idx][victim]) ? S_WB : S_FILL;
            end
         end
         S_WB: begin
            pmem_write   = 1'b1;
            pmem_address = {tag_mem[idx][victim_q], idx, {OFS{1'b0}}};
            pmem_wdata   = data_mem[idx][victim_q];
            if (pmem_resp) begin
               dirty_d[idx][victim_q] = 1'b0;
               state_d                = S_FILL;
            end
         end
         S_FILL: begin
            pmem_read    = 1'b1;
            pmem_address = {req_tag, idx, {OFS{1'b0}}};
            if (pmem_resp) begin
               line_we                = 1'b1;
               tag_we                 = 1'b1;
               line_way               = victim_q;
               line_data              = pmem_rdata;
               valid_d[idx][victim_q] = 1'b1;
               dirty_d[idx][victim_q] = 1'b0;
               state_d                = S_CHECK;   // re-check hits and completes
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         line_q   <= '0;
         wr_q     <= 1'b0;
         victim_q <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            plru_q[s]  <= '0;
         end
      end else begin
         state_q  <= state_d;
         line_q   <= line_d;
         wr_q     <= wr_d;
         victim_q <= victim_d;
         valid_q  <= valid_d;
         dirty_q  <= dirty_d;
         plru_q   <= plru_d;
      end
   end

   // Line and tag storage are not reset; a write in a reset cycle is dropped.
   always_ff @(posedge clk) begin
      if (rst_n && line_we) data_mem[idx][line_way] <= line_data;
      if (rst_n && tag_we)  tag_mem[idx][victim_q]  <= req_tag;
   end

endmodule
